// File: rtl/zigzag_rle_if.sv
// +--------------------------------------------------------------------------+
// | zigzag_rle_if: block input and symbol output bundle for zigzag_rle.      |
// | Rev 1.0 - initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

interface zigzag_rle_if #(
  parameter int MCU_SIZE      = 8,
  parameter int QUAN_BITWIDTH = 12
);
  localparam int AMP_BITWIDTH = QUAN_BITWIDTH + 1;

  logic [MCU_SIZE-1:0][MCU_SIZE-1:0][QUAN_BITWIDTH-1:0] quan_data;
  logic                    in_valid;
  logic                    in_busy;
  logic                    dc_clear;
  logic                    out_valid;
  logic                    out_ready;
  logic [3:0]              out_run;
  logic [3:0]              out_size;
  logic [AMP_BITWIDTH-1:0] out_amp;
  logic                    out_is_dc;
  logic                    out_eob;

  modport master (
    output quan_data, in_valid, dc_clear, out_ready,
    input  in_busy, out_valid, out_run, out_size, out_amp, out_is_dc, out_eob
  );

  modport slave (
    input  quan_data, in_valid, dc_clear, out_ready,
    output in_busy, out_valid, out_run, out_size, out_amp, out_is_dc, out_eob
  );
endinterface

`default_nettype wire

// File: rtl/zigzag_rle.sv
// +--------------------------------------------------------------------------+
// | zigzag_rle: zigzag readout, DC differencing and AC run-length symbols.   |
// | Rev 1.0 - initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module zigzag_rle #(
  parameter int MCU_SIZE      = 8,
  parameter int QUAN_BITWIDTH = 12
) (
  input  logic         clk,
  input  logic         n_rst,
  zigzag_rle_if.slave  bus
);
  localparam int AMP_BITWIDTH = QUAN_BITWIDTH + 1;
  localparam int NCOEF        = MCU_SIZE * MCU_SIZE;

  typedef enum logic [1:0] {IDLE = 2'd0, DC = 2'd1, AC = 2'd2} state_t;

  function automatic int zz_raster(input int k);
    int r;
    int c;
    r = 0;
    c = 0;
    for (int s = 0; s < k; s++) begin
      if (((r + c) % 2) == 0) begin
        if (c == MCU_SIZE - 1) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == MCU_SIZE - 1) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
    return r * MCU_SIZE + c;
  endfunction

  function automatic logic [3:0] cat_f(input logic signed [AMP_BITWIDTH-1:0] x);
    logic [AMP_BITWIDTH-1:0] mag;
    mag   = x[AMP_BITWIDTH-1] ? -x : x;
    cat_f = '0;
    for (int i = 0; i < AMP_BITWIDTH; i++)
      if (mag[i]) cat_f = 4'(i + 1);
  endfunction

  // Negative values are sent as ones' complement truncated to the category.
  function automatic logic [AMP_BITWIDTH-1:0] enc_f(input logic signed [AMP_BITWIDTH-1:0] x,
                                                    input logic [3:0] sz);
    logic [AMP_BITWIDTH-1:0] mask;
    mask  = ~({AMP_BITWIDTH{1'b1}} << sz);
    enc_f = x[AMP_BITWIDTH-1] ? ((x - AMP_BITWIDTH'(1)) & mask) : x;
  endfunction

  state_t                      state_q, state_d;
  logic [5:0]                  k_q, k_d;
  logic [5:0]                  zrun_q, zrun_d;
  logic [QUAN_BITWIDTH-1:0]    dc_pred_q, dc_pred_d;
  logic [AMP_BITWIDTH-1:0]     dc_diff_q, dc_diff_d;
  logic [QUAN_BITWIDTH-1:0]    buf_q [NCOEF];
  logic [QUAN_BITWIDTH-1:0]    w_zz  [NCOEF];

  logic                        w_valid, w_is_dc, w_eob;
  logic [3:0]                  w_run, w_size, w_coef_size, w_dc_size;
  logic [AMP_BITWIDTH-1:0]     w_amp, w_coef, w_q00;

  for (genvar g = 0; g < NCOEF; g++) begin : g_zz
    localparam int RASTER = zz_raster(g);
    assign w_zz[g] = bus.quan_data[RASTER / MCU_SIZE][RASTER % MCU_SIZE];
  end

  assign w_q00       = {w_zz[0][QUAN_BITWIDTH-1], w_zz[0]};
  assign w_coef      = {buf_q[k_q][QUAN_BITWIDTH-1], buf_q[k_q]};
  assign w_coef_size = cat_f(w_coef);
  assign w_dc_size   = cat_f(dc_diff_q);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      zrun_q    <= '0;
      dc_pred_q <= '0;
      dc_diff_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      zrun_q    <= zrun_d;
      dc_pred_q <= dc_pred_d;
      dc_diff_q <= dc_diff_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_valid) buf_q <= w_zz;
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    zrun_d    = zrun_q;
    dc_pred_d = dc_pred_q;
    dc_diff_d = dc_diff_q;
    w_valid   = 1'b0;
    w_run     = '0;
    w_size    = '0;
    w_amp     = '0;
    w_is_dc   = 1'b0;
    w_eob     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Difference is frozen at capture so a later dc_clear cannot disturb a stalled DC symbol.
          dc_diff_d = w_q00 - (bus.dc_clear ? '0 : {dc_pred_q[QUAN_BITWIDTH-1], dc_pred_q});
          state_d   = DC;
        end
      end
      DC: begin
        w_valid = 1'b1;
        w_is_dc = 1'b1;
        w_size  = w_dc_size;
        w_amp   = enc_f(dc_diff_q, w_dc_size);
        if (bus.out_ready) begin
          dc_pred_d = buf_q[0];
          k_d       = 6'd1;
          zrun_d    = '0;
          state_d   = AC;
        end
      end
      AC: begin
        if (w_coef == '0) begin
          if (k_q == 6'd63) begin
            w_valid = 1'b1;
            w_eob   = 1'b1;
            if (bus.out_ready) state_d = IDLE;
          end else begin
            zrun_d = zrun_q + 6'd1;
            k_d    = k_q + 6'd1;
          end
        end else if (zrun_q >= 6'd16) begin
          w_valid = 1'b1;
          w_run   = 4'd15;
          if (bus.out_ready) zrun_d = zrun_q - 6'd16;
        end else begin
          w_valid = 1'b1;
          w_run   = zrun_q[3:0];
          w_size  = w_coef_size;
          w_amp   = enc_f(w_coef, w_coef_size);
          if (bus.out_ready) begin
            zrun_d = '0;
            if (k_q == 6'd63) state_d = IDLE;
            else              k_d     = k_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.dc_clear) dc_pred_d = '0;
  end

  assign bus.in_busy   = (state_q != IDLE);
  assign bus.out_valid = w_valid;
  assign bus.out_run   = w_run;
  assign bus.out_size  = w_size;
  assign bus.out_amp   = w_amp;
  assign bus.out_is_dc = w_is_dc;
  assign bus.out_eob   = w_eob;

endmodule

`default_nettype wire

// File: tb/tb_zigzag_rle.sv
// +--------------------------------------------------------------------------+
// | tb_zigzag_rle: directed block vectors checked against expected symbols.  |
// | Rev 1.0 - initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_zigzag_rle;
  typedef logic [22:0] sym_t; // {is_dc, eob, run[3:0], size[3:0], amp[12:0]}

  typedef struct {
    int             dc;
    int             pos_a;
    int             val_a;
    int             pos_b;
    int             val_b;
    bit             clr;
    int             stall;
    int             nsym;
    logic [5:0][22:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vecs [9];

  always #5 clk = ~clk;

  zigzag_rle_if #(.MCU_SIZE(8), .QUAN_BITWIDTH(12)) bus ();

  zigzag_rle #(.MCU_SIZE(8), .QUAN_BITWIDTH(12)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  sym_t w_cur;
  assign w_cur = {bus.out_is_dc, bus.out_eob, bus.out_run, bus.out_size, bus.out_amp};

  function automatic sym_t s(bit dc, bit eob, int run, int size, int amp);
    return {dc, eob, 4'(run), 4'(size), 13'(amp)};
  endfunction

  function automatic vec_t mkvec(int dc, int pa, int va, int pb, int vb, bit clr, int stall);
    vec_t v;
    v.dc = dc; v.pos_a = pa; v.val_a = va; v.pos_b = pb; v.val_b = vb;
    v.clr = clr; v.stall = stall; v.nsym = 0; v.exp = '0;
    return v;
  endfunction

  task automatic add(input int vi, input sym_t x);
    vecs[vi].exp[vecs[vi].nsym] = x;
    vecs[vi].nsym++;
  endtask

  task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic load_block(input int vi);
    bus.quan_data = '0;
    bus.quan_data[0][0] = 12'(vecs[vi].dc);
    if (vecs[vi].pos_a >= 0) bus.quan_data[vecs[vi].pos_a / 8][vecs[vi].pos_a % 8] = 12'(vecs[vi].val_a);
    if (vecs[vi].pos_b >= 0) bus.quan_data[vecs[vi].pos_b / 8][vecs[vi].pos_b % 8] = 12'(vecs[vi].val_b);
    bus.in_valid = 1'b1;
    bus.dc_clear = vecs[vi].clr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dc_clear = 1'b0;
  endtask

  task automatic run_block(input int vi);
    sym_t got [$];
    sym_t snap;
    int   cyc;
    bit   stalled;
    load_block(vi);
    cyc = 0;
    stalled = 1'b0;
    while (bus.in_busy && cyc < 300) begin
      if (bus.out_valid && !stalled && vecs[vi].stall == got.size()) begin
        stalled = 1'b1;
        snap = w_cur;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check(w_cur == snap && bus.out_valid && bus.in_busy,
                $sformatf("vec%0d stall_hold", vi),
                {6'b0, bus.in_busy, bus.out_valid, 1'b0, w_cur}, {8'b1, 1'b0, snap});
        end
        bus.out_ready = 1'b1;
        continue;
      end
      if (bus.out_valid && bus.out_ready) got.push_back(w_cur);
      @(negedge clk);
      cyc++;
    end
    check(cyc < 300, $sformatf("vec%0d timeout", vi), cyc, 300);
    check(got.size() == vecs[vi].nsym, $sformatf("vec%0d symbol_count", vi), got.size(), vecs[vi].nsym);
    for (int j = 0; j < vecs[vi].nsym; j++) begin
      if (j < got.size())
        check(got[j] == vecs[vi].exp[j], $sformatf("vec%0d sym%0d", vi, j),
              32'(got[j]), 32'(vecs[vi].exp[j]));
    end
  endtask

  initial begin
    vecs[0] = mkvec(0, -1, 0, -1, 0, 1'b0, -1);
    add(0, s(1,0,0,0,0)); add(0, s(0,1,0,0,0));
    vecs[1] = mkvec(-5, -1, 0, -1, 0, 1'b0, -1);
    add(1, s(1,0,0,3,2)); add(1, s(0,1,0,0,0));
    vecs[2] = mkvec(3, -1, 0, -1, 0, 1'b0, -1);
    add(2, s(1,0,0,4,8)); add(2, s(0,1,0,0,0));
    // k=1 is [0][1] (raster 1), k=35 is [7][0] (raster 56).
    vecs[3] = mkvec(3, 1, 1, 56, -1, 1'b0, -1);
    add(3, s(1,0,0,0,0)); add(3, s(0,0,0,1,1)); add(3, s(0,0,15,0,0));
    add(3, s(0,0,15,0,0)); add(3, s(0,0,1,1,0)); add(3, s(0,1,0,0,0));
    vecs[4] = vecs[3];
    vecs[4].stall = 1;
    vecs[5] = mkvec(3, 63, 2, -1, 0, 1'b0, -1);
    add(5, s(1,0,0,0,0)); add(5, s(0,0,15,0,0)); add(5, s(0,0,15,0,0));
    add(5, s(0,0,15,0,0)); add(5, s(0,0,14,2,2));
    vecs[6] = mkvec(7, -1, 0, -1, 0, 1'b0, -1);
    add(6, s(1,0,0,3,4)); add(6, s(0,1,0,0,0));
    vecs[7] = mkvec(7, -1, 0, -1, 0, 1'b1, -1);
    add(7, s(1,0,0,3,7)); add(7, s(0,1,0,0,0));
    vecs[8] = mkvec(7, -1, 0, -1, 0, 1'b0, -1);
    add(8, s(1,0,0,3,7)); add(8, s(0,1,0,0,0));

    n_rst         = 1'b0;
    bus.quan_data = '0;
    bus.in_valid  = 1'b0;
    bus.dc_clear  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check(!bus.out_valid, "reset out_valid", 32'(bus.out_valid), 0);
    check(!bus.in_busy, "reset in_busy", 32'(bus.in_busy), 0);
    check(w_cur == '0, "reset outputs", 32'(w_cur), 0);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_block(i);

    // Abandon a block part-way through its AC scan.
    load_block(3);
    repeat (10) @(negedge clk);
    check(bus.in_busy, "midblock busy", 32'(bus.in_busy), 1);
    n_rst = 1'b0;
    @(negedge clk);
    check(!bus.out_valid, "midreset out_valid", 32'(bus.out_valid), 0);
    check(!bus.in_busy, "midreset in_busy", 32'(bus.in_busy), 0);
    n_rst = 1'b1;
    @(negedge clk);
    run_block(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
